// File: rtl/i2c_target.sv
// i2c_target: oversampled byte-level I2C target with a register file, a register pointer and a local update port.
// Build option: define I2C_TARGET_AUTOINC_EN to advance the pointer after each written byte and each ACKed read byte.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h1D,
  parameter int         NUM_REGS    = 64,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic       upd_en,
  input  logic [7:0] upd_addr,
  input  logic [7:0] upd_data,
  output logic       bus_wr_strobe,
  output logic [7:0] bus_wr_addr,
  output logic [7:0] bus_wr_data,
  output logic       busy,
  output logic [3:0] dbg_state
);
`ifdef I2C_TARGET_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  localparam int AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    REG       = 4'd3,
    REG_ACK   = 4'd4,
    WRITE     = 4'd5,
    WRITE_ACK = 4'd6,
    READ      = 4'd7,
    READ_ACK  = 4'd8,
    IGNORE    = 4'd9
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic [7:0]             regs_q [DEPTH];

  state_t     state_q;
  logic [7:0] ptr_q, sr_q, tx_q, wr_addr_q, wr_data_q;
  logic [3:0] cnt_q;
  logic       sda_oe_q, busy_q, strobe_q, ack_drv_q, rw_q, mack_q;

  // Bus idles high, so synchronizers reset to 1 to avoid a phantom START/STOP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  function automatic logic [7:0] rd_at(input logic [7:0] a);
    return (int'(a) < NUM_REGS) ? regs_q[a[AW-1:0]] : 8'h00;
  endfunction

  logic [7:0] sr_next, ptr_inc, ptr_after, rd_cur, rd_after;
  logic       bus_we;
  assign sr_next   = {sr_q[6:0], sda_s};
  assign ptr_inc   = ptr_q + 8'd1;
  assign ptr_after = AUTOINC ? ptr_inc : ptr_q;
  assign rd_cur    = rd_at(ptr_q);
  assign rd_after  = rd_at(ptr_after);
  assign bus_we    = (state_q == WRITE) && scl_rise && !start_det && !stop_det &&
                     (cnt_q == 4'd7) && (int'(ptr_q) < NUM_REGS);

  // Bus write is placed last so it overrides a same-cycle local update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= (i == 0) ? 8'hE5 : 8'h00;
    end else begin
      if (upd_en && (int'(upd_addr) < NUM_REGS)) regs_q[upd_addr[AW-1:0]] <= upd_data;
      if (bus_we) regs_q[ptr_q[AW-1:0]] <= sr_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= 8'h00;
      sr_q      <= 8'h00;
      tx_q      <= 8'h00;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
      cnt_q     <= 4'd0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      strobe_q  <= 1'b0;
      ack_drv_q <= 1'b0;
      rw_q      <= 1'b0;
      mack_q    <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (start_det || stop_det) begin
        state_q   <= start_det ? ADDR : IDLE;
        cnt_q     <= 4'd0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
        ack_drv_q <= 1'b0;
      end else begin
        case (state_q)
          ADDR, REG, WRITE: if (scl_rise) begin
            sr_q  <= sr_next;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_q <= 4'd0;
              if (state_q == ADDR) begin
                if (sr_q[6:0] == DEV_ADDR) begin
                  state_q <= ADDR_ACK;
                  rw_q    <= sda_s;
                  busy_q  <= 1'b1;
                end else begin
                  state_q <= IGNORE;
                end
              end else if (state_q == REG) begin
                ptr_q   <= sr_next;
                state_q <= REG_ACK;
              end else begin
                strobe_q  <= bus_we;
                wr_addr_q <= bus_we ? ptr_q : wr_addr_q;
                wr_data_q <= bus_we ? sr_next : wr_data_q;
                ptr_q     <= ptr_after;
                state_q   <= WRITE_ACK;
              end
            end
          end
          // First falling edge starts the ACK low, the second ends it.
          ADDR_ACK, REG_ACK, WRITE_ACK: if (scl_fall) begin
            if (!ack_drv_q) begin
              ack_drv_q <= 1'b1;
              sda_oe_q  <= 1'b1;
            end else begin
              ack_drv_q <= 1'b0;
              sda_oe_q  <= 1'b0;
              cnt_q     <= 4'd0;
              if (state_q == ADDR_ACK && rw_q) begin
                tx_q     <= rd_cur;
                sda_oe_q <= ~rd_cur[7];
                state_q  <= READ;
              end else begin
                state_q <= (state_q == ADDR_ACK) ? REG : WRITE;
              end
            end
          end
          READ: begin
            if (scl_rise) begin
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                state_q  <= READ_ACK;
              end else begin
                tx_q     <= {tx_q[6:0], 1'b0};
                sda_oe_q <= ~tx_q[6];
              end
            end
          end
          READ_ACK: begin
            if (scl_rise) begin
              mack_q <= ~sda_s;
            end else if (scl_fall) begin
              if (mack_q) begin
                cnt_q    <= 4'd0;
                ptr_q    <= ptr_after;
                tx_q     <= rd_after;
                sda_oe_q <= ~rd_after[7];
                state_q  <= READ;
              end else begin
                state_q <= IGNORE;
              end
            end
          end
          IDLE, IGNORE: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sda_oe        = sda_oe_q;
  assign busy          = busy_q;
  assign bus_wr_strobe = strobe_q;
  assign bus_wr_addr   = wr_addr_q;
  assign bus_wr_data   = wr_data_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-banged I2C master against a register-map model with a strobe scoreboard.
module tb_i2c_target;
  localparam logic [6:0] DEV   = 7'h1D;
  localparam int         NREGS = 64;
  localparam int         Q     = 8;
`ifdef I2C_TARGET_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  // ---------------- clock / reset / bus ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic m_scl = 1'b1, m_sda = 1'b1;
  logic upd_en = 1'b0;
  logic [7:0] upd_addr = 8'h00, upd_data = 8'h00;
  logic sda_oe, bus_wr_strobe, busy;
  logic [7:0] bus_wr_addr, bus_wr_data;
  logic [3:0] dbg_state;
  logic sda_bus;
  assign sda_bus = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target #(.DEV_ADDR(DEV), .NUM_REGS(NREGS), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(sda_bus), .sda_oe(sda_oe),
    .upd_en(upd_en), .upd_addr(upd_addr), .upd_data(upd_data),
    .bus_wr_strobe(bus_wr_strobe), .bus_wr_addr(bus_wr_addr), .bus_wr_data(bus_wr_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- model and scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic quiet = 1'b0;
  logic [15:0] exp_q[$];
  logic [7:0] mdl_regs[256];
  logic [7:0] mdl_ptr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void mdl_reset();
    for (int i = 0; i < 256; i++) mdl_regs[i] = 8'h00;
    mdl_regs[0] = 8'hE5;
    mdl_ptr = 8'h00;
  endfunction

  function automatic logic [7:0] mdl_rd();
    return (int'(mdl_ptr) < NREGS) ? mdl_regs[mdl_ptr] : 8'h00;
  endfunction

  logic prev_scl = 1'b1, prev_oe = 1'b0;
  always begin
    @(posedge clk);
    #2;
    if (rst) begin
      if (bus_wr_strobe) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL strobe: got addr %0h data %0h expected no strobe", bus_wr_addr, bus_wr_data);
        end else begin
          chk("strobe", {bus_wr_addr, bus_wr_data}, exp_q.pop_front());
        end
      end
      if (quiet) chk("quiet_oe", sda_oe, 1'b0);
      if (m_scl && prev_scl) chk("oe_stable_scl_high", sda_oe, prev_oe);
    end
    prev_scl = m_scl;
    prev_oe  = sda_oe;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_io(input logic b, output logic s);
    m_sda = b;
    wait_clks(Q);
    m_scl = 1'b1;
    wait_clks(Q / 2);
    s = sda_bus;
    wait_clks(Q / 2);
    m_scl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic m_start();
    m_sda = 1'b1; wait_clks(Q);
    m_scl = 1'b1; wait_clks(Q);
    m_sda = 1'b0; wait_clks(Q);
    m_scl = 1'b0; wait_clks(Q);
  endtask

  task automatic m_stop();
    m_sda = 1'b0; wait_clks(Q);
    m_scl = 1'b1; wait_clks(Q);
    m_sda = 1'b1; wait_clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(d[i], s);
    bit_io(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s);
      d[i] = s;
    end
    bit_io(~ack, s);
  endtask

  task automatic m_addr(input logic [6:0] a, input logic rw);
    logic ack;
    send_byte({a, rw}, ack);
    chk("addr_ack", ack, (a == DEV));
    if (a == DEV) chk("busy_after_match", busy, 1'b1);
  endtask

  task automatic m_wreg(input logic [7:0] r);
    logic ack;
    send_byte(r, ack);
    chk("reg_ack", ack, 1'b1);
    mdl_ptr = r;
  endtask

  task automatic m_wdata(input logic [7:0] d);
    logic ack;
    if (int'(mdl_ptr) < NREGS) begin
      mdl_regs[mdl_ptr] = d;
      exp_q.push_back({mdl_ptr, d});
    end
    if (AUTOINC) mdl_ptr = mdl_ptr + 8'd1;
    send_byte(d, ack);
    chk("data_ack", ack, 1'b1);
  endtask

  task automatic m_rdata(input logic ack, output logic [7:0] d);
    logic [7:0] e;
    e = mdl_rd();
    recv_byte(ack, d);
    chk("rdata", d, e);
    if (ack && AUTOINC) mdl_ptr = mdl_ptr + 8'd1;
  endtask

  task automatic do_upd(input logic [7:0] a, input logic [7:0] d);
    upd_en = 1'b1; upd_addr = a; upd_data = d;
    wait_clks(1);
    upd_en = 1'b0;
    if (int'(a) < NREGS) mdl_regs[a] = d;
  endtask

  task automatic read_from(input logic [7:0] r, input int n, output logic [7:0] last);
    logic [7:0] d;
    m_start(); m_addr(DEV, 1'b0); m_wreg(r);
    m_start(); m_addr(DEV, 1'b1);
    for (int i = 0; i < n; i++) m_rdata(i != n - 1, d);
    last = d;
    m_stop();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] d, d0, d1, d2, r;
    logic ack, s;
    logic [6:0] a;
    int n;
    mdl_reset();
    #1;
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_strobe", bus_wr_strobe, 1'b0);
    chk("rst_wr_addr", bus_wr_addr, 8'h00);
    chk("rst_wr_data", bus_wr_data, 8'h00);
    chk("rst_state", dbg_state, 4'd0);
    wait_clks(3);
    rst = 1'b1;
    wait_clks(5);

    // Write 0x2D = 0x08 then read it back.
    m_start(); m_addr(DEV, 1'b0); m_wreg(8'h2D); m_wdata(8'h08); m_stop();
    chk("busy_after_stop", busy, 1'b0);
    read_from(8'h2D, 1, d);
    chk("lit_2d", d, 8'h08);

    // DEVID through a repeated START.
    read_from(8'h00, 1, d);
    chk("lit_devid", d, 8'hE5);
    chk("busy_after_rd_stop", busy, 1'b0);

    // Foreign address: no ACK, SDA untouched.
    quiet = 1'b1;
    m_start(); m_addr(7'h53, 1'b0);
    send_byte(8'h2D, ack);
    chk("foreign_data_nack", ack, 1'b0);
    m_stop();
    quiet = 1'b0;

    // Local updates then a 3-byte read burst across the top of the map.
    do_upd(8'h3E, 8'h11);
    do_upd(8'h3F, 8'h22);
    do_upd(8'h80, 8'h77);
    m_start(); m_addr(DEV, 1'b0); m_wreg(8'h3E);
    m_start(); m_addr(DEV, 1'b1);
    m_rdata(1'b1, d0); m_rdata(1'b1, d1); m_rdata(1'b0, d2);
    m_stop();
    chk("lit_burst0", d0, 8'h11);
    chk("lit_burst1", d1, AUTOINC ? 8'h22 : 8'h11);
    chk("lit_burst2", d2, AUTOINC ? 8'h00 : 8'h11);

    // Write burst starting at 0xFF.
    m_start(); m_addr(DEV, 1'b0); m_wreg(8'hFF); m_wdata(8'hAA); m_wdata(8'h55); m_stop();
    read_from(8'h00, 1, d);
    chk("lit_wrap", d, AUTOINC ? 8'h55 : 8'hE5);

    // Reset during the 4th data bit of a read (0x20 = 0xA5, 4th bit is 0).
    do_upd(8'h20, 8'hA5);
    m_start(); m_addr(DEV, 1'b0); m_wreg(8'h20);
    m_start(); m_addr(DEV, 1'b1);
    for (int i = 0; i < 3; i++) bit_io(1'b1, s);
    m_sda = 1'b1;
    wait_clks(Q);
    chk("oe_before_rst", sda_oe, 1'b1);
    rst = 1'b0;
    #1;
    chk("rst_mid_oe", sda_oe, 1'b0);
    chk("rst_mid_state", dbg_state, 4'd0);
    chk("rst_mid_busy", busy, 1'b0);
    mdl_reset();
    exp_q.delete();
    m_scl = 1'b1;
    wait_clks(3);
    rst = 1'b1;
    wait_clks(Q);
    m_start(); m_addr(DEV, 1'b1); m_rdata(1'b0, d); m_stop();
    chk("lit_post_rst_ptr0", d, 8'hE5);
    m_start(); m_addr(DEV, 1'b0); m_wreg(8'h10); m_wdata(8'h5A); m_stop();
    read_from(8'h10, 1, d);
    chk("lit_post_rst_rw", d, 8'h5A);

    // Randomized transactions.
    for (int t = 0; t < 25; t++) begin
      r = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, NREGS - 1)) : 8'($urandom_range(0, 255));
      n = $urandom_range(1, 3);
      case ($urandom_range(0, 4))
        0: begin
          m_start(); m_addr(DEV, 1'b0); m_wreg(r);
          for (int i = 0; i < n; i++) m_wdata(8'($urandom_range(0, 255)));
          m_stop();
        end
        1: read_from(r, n, d);
        2: begin
          do a = 7'($urandom_range(0, 127)); while (a == DEV);
          quiet = 1'b1;
          m_start(); m_addr(a, 1'($urandom_range(0, 1))); m_stop();
          quiet = 1'b0;
        end
        3: do_upd(r, 8'($urandom_range(0, 255)));
        default: begin
          m_start(); m_addr(DEV, 1'b1);
          for (int i = 0; i < n; i++) m_rdata(i != n - 1, d);
          m_stop();
        end
      endcase
      chk("busy_idle", busy, 1'b0);
    end

    wait_clks(20);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_target.md
# i2c_target

Byte-level I2C target (responder) modelling the accelerometer end of the GSENSOR bus. It is oversampled on the system clock and holds a 8-bit-addressed register file with a register pointer. It lets the I2C controller be exercised in simulation and, if needed, in hardware against a known register map. Local sensor logic loads registers through an update port. Master writes are reported on a one-cycle strobe.

## Interface
- DEV_ADDR, 7'h1D: 7-bit target address matched after START.
- NUM_REGS, 64: implemented registers, 1..256; pointer addresses at or above NUM_REGS are unimplemented.
- SYNC_STAGES, 2: synchronizer depth on scl_i/sda_i, minimum 2.
- clk  input  1  system clock, at least 20x SCL rate.
- rst  input  1  reset, asynchronous and active-low.
- scl_i  input  1  bus SCL level (pulled-up wire).
- sda_i  input  1  bus SDA level (pulled-up wire).
- sda_oe  output  1  1 = pull SDA low; top level drives SDA to 0 when set, else Z.
- upd_en  input  1  local register write.
- upd_addr  input  8  local write address.
- upd_data  input  8  local write data.
- bus_wr_strobe  output  1  one-cycle pulse per data byte written by master.
- bus_wr_addr  output  8  register address of that byte.
- bus_wr_data  output  8  byte written.
- busy  output  1  high from own-address match until STOP/START.
- dbg_state  output  4  current FSM state encoding.

## Operation
- Inputs pass through SYNC_STAGES flops, then one edge-detect flop.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- Data is sampled on SCL rising edges, MSB first. Target drives SDA only on SCL falling edges.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
- IDLE: on START go to ADDR.
- ADDR: shift 8 bits. On address match go to ADDR_ACK; on mismatch go to IGNORE (no ACK).
- ADDR_ACK: drive ACK for one SCL period. R/W=0 then REG; R/W=1 then load the read byte from the pointer and go to READ.
- REG: 8 bits, then pointer <= byte, REG_ACK, then WRITE.
- WRITE: 8 bits, then reg[pointer] <= byte, strobe, WRITE_ACK; pointer increments, then back to WRITE.
- READ: shift the byte out, then READ_ACK samples the master bit.
  - ACK: pointer increments, load the next byte, READ.
  - NACK: IGNORE.
- IGNORE: sda_oe=0 until START (go to ADDR) or STOP (go to IDLE).
- START or STOP in any state aborts the current byte. An aborted partial byte is discarded. Repeated START is supported; pointer is retained.
- Pointer is 8 bits and wraps 0xFF to 0x00.
- Unimplemented addresses: bus writes are ACKed and dropped, with no strobe. Reads return 0x00.
- Reset values: register 0x00 = 0xE5 (DEVID), all others 0x00; pointer 0x00.
- upd_en and a bus write to the same address in the same cycle: bus write wins. upd_en to an unimplemented address is ignored.

## Timing
- Pin-to-event detection latency: SYNC_STAGES+1 clk.
- sda_oe changes within SYNC_STAGES+2 clk after SCL falls, and is stable while SCL is high.
- ACK bit: sda_oe=1 from the falling edge after the 8th bit until the next falling edge.
- bus_wr_strobe: asserted 1 clk after the 8th rising edge of a write byte; address and data are valid in the same cycle.
- Read byte is latched from the register file at the falling edge that starts the byte. An upd_en arriving later lands in the next read.
- Reset (asynchronous, rst=0) values:
  - FSM IDLE.
  - sda_oe=0, busy=0, bus_wr_strobe=0.
  - bus_wr_addr/data=0.
  - Registers and pointer at their reset values.
- Reset mid-transfer releases SDA immediately. The FSM then waits in IDLE for a fresh START.

## Configuration
- I2C_TARGET_AUTOINC_EN defined: pointer increments after every written byte and every ACKed read byte.
- I2C_TARGET_AUTOINC_EN undefined: pointer changes only in REG. Bursts repeatedly write or read the same register.

## Test plan
- Write 0x1D/W, reg 0x2D, data 0x08, STOP:
  - three ACKs.
  - strobe with addr 0x2D, data 0x08.
  - a later read of 0x2D returns 0x08.
- Write 0x1D/W reg 0x00, repeated START, 0x1D/R, NACK, STOP: master receives 0xE5; busy drops after STOP.
- Address 0x53/W: no ACK (SDA high on 9th clock), sda_oe stays 0 for the whole transaction, no strobe.
- With NUM_REGS=64, upd_en loads 0x3E=0x11 and 0x3F=0x22; read burst from 0x3E, 3 bytes:
  - AUTOINC_EN: 0x11, 0x22, 0x00.
  - without AUTOINC_EN: 0x11, 0x11, 0x11.
- Write burst starting at 0xFF with 2 bytes: first byte dropped with no strobe; second lands at 0x00 (AUTOINC_EN).
- Assert rst during the 4th data bit of a read: sda_oe=0 within the same cycle, dbg_state=IDLE. The next full transaction succeeds.
